cpu_decode_pipe: RTL and testbench

Parametrised decode stage for the moxie core, sitting between fetch and execute. Decodes 16-bit moxie opcodes (form 1/2/3) into op code, register indices, operand and register-file enables, and presents them through a one-entry registered output slot with a valid/ready handshake in place of a bare stall. An internal register scoreboard holds back instructions with RAW/WAW hazards against in-flight writes until writeback clears them.

---
 rtl/cpu_pkg.sv | 189 ++++++++++++++++++
 rtl/cpu_scoreboard.sv | 55 +++++
 rtl/cpu_decode_pipe.sv | 139 +++++++++++++
 tb/tb_cpu_decode_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared moxie decode definitions: op code constants, instruction form masks,
// the form-1 enable table and the opcode-to-fields decode function.
package cpu_pkg;

  localparam int OP_CODE_W = 6;
  localparam int NUM_REGS  = 16;

  typedef logic [OP_CODE_W-1:0] op_t;

  localparam op_t OP_NOP    = 6'd0;
  localparam op_t OP_BAD    = 6'd1;
  localparam op_t OP_LDI_L  = 6'd2;
  localparam op_t OP_MOV    = 6'd3;
  localparam op_t OP_ADD_L  = 6'd4;
  localparam op_t OP_AND    = 6'd5;
  localparam op_t OP_SUB_L  = 6'd6;
  localparam op_t OP_OR     = 6'd7;
  localparam op_t OP_XOR    = 6'd8;
  localparam op_t OP_MUL_L  = 6'd9;
  localparam op_t OP_DIV_L  = 6'd10;
  localparam op_t OP_UDIV_L = 6'd11;
  localparam op_t OP_MOD_L  = 6'd12;
  localparam op_t OP_UMOD_L = 6'd13;
  localparam op_t OP_INC    = 6'd14;
  localparam op_t OP_DEC    = 6'd15;
  localparam op_t OP_GSR    = 6'd16;
  localparam op_t OP_SSR    = 6'd17;
  localparam op_t OP_BEQ    = 6'd18;
  localparam op_t OP_BNE    = 6'd19;
  localparam op_t OP_BLT    = 6'd20;
  localparam op_t OP_BGT    = 6'd21;
  localparam op_t OP_BLTU   = 6'd22;
  localparam op_t OP_BGTU   = 6'd23;
  localparam op_t OP_BGE    = 6'd24;
  localparam op_t OP_BLE    = 6'd25;
  localparam op_t OP_BGEU   = 6'd26;
  localparam op_t OP_BLEU   = 6'd27;
  localparam op_t OP_JSRA   = 6'd28;
  localparam op_t OP_RET    = 6'd29;
  localparam op_t OP_PUSH   = 6'd30;
  localparam op_t OP_POP    = 6'd31;
  localparam op_t OP_LDA_L  = 6'd32;
  localparam op_t OP_STA_L  = 6'd33;
  localparam op_t OP_LD_L   = 6'd34;
  localparam op_t OP_ST_L   = 6'd35;
  localparam op_t OP_LDO_L  = 6'd36;
  localparam op_t OP_STO_L  = 6'd37;
  localparam op_t OP_CMP    = 6'd38;
  localparam op_t OP_SEX_B  = 6'd39;
  localparam op_t OP_SEX_S  = 6'd40;
  localparam op_t OP_ZEX_B  = 6'd41;
  localparam op_t OP_ZEX_S  = 6'd42;
  localparam op_t OP_UMUL_X = 6'd43;
  localparam op_t OP_MUL_X  = 6'd44;
  localparam op_t OP_JSR    = 6'd45;
  localparam op_t OP_JMPA   = 6'd46;
  localparam op_t OP_JMP    = 6'd47;
  localparam op_t OP_LSHR   = 6'd48;
  localparam op_t OP_ASHL   = 6'd49;
  localparam op_t OP_ASHR   = 6'd50;
  localparam op_t OP_NEG    = 6'd51;
  localparam op_t OP_NOT    = 6'd52;
  localparam op_t OP_SWI    = 6'd53;
  localparam op_t OP_BRK    = 6'd54;

  localparam logic [15:0] FORM_MASK   = 16'hC000;
  localparam logic [15:0] FORM2_BITS  = 16'h8000;
  localparam logic [15:0] FORM3_BITS  = 16'hC000;
  localparam logic [3:0]  BRANCH_LAST = 4'd9;

  typedef enum logic [1:0] {
    OPND_NONE = 2'd0,
    OPND_LONG = 2'd1,
    OPND_ZX8  = 2'd2,
    OPND_SX10 = 2'd3
  } opnd_sel_e;

  typedef struct packed {
    op_t  op;
    logic rd;
    logic wr;
    logic lng;
  } f1_entry_t;

  typedef struct packed {
    op_t        op;
    logic [3:0] reg_a;
    logic [3:0] reg_b;
    logic [3:0] dest;
    logic       rd;
    logic       wr;
    opnd_sel_e  opnd;
  } dec_t;

  // Form-1 table: {op, reads regA/regB, writes [7:4], trailing immediate word}.
  // Sub-word memory forms are not handled by execute and decode as bad.
  function automatic f1_entry_t f1_lookup(input logic [7:0] code);
    f1_entry_t e;
    case (code)
      8'h00:   e = '{OP_NOP,    1'b0, 1'b0, 1'b0};
      8'h01:   e = '{OP_LDI_L,  1'b0, 1'b1, 1'b1};
      8'h02:   e = '{OP_MOV,    1'b1, 1'b1, 1'b0};
      8'h03:   e = '{OP_JSRA,   1'b0, 1'b0, 1'b1};
      8'h04:   e = '{OP_RET,    1'b0, 1'b0, 1'b0};
      8'h05:   e = '{OP_ADD_L,  1'b1, 1'b1, 1'b0};
      8'h06:   e = '{OP_PUSH,   1'b1, 1'b1, 1'b0};
      8'h07:   e = '{OP_POP,    1'b1, 1'b1, 1'b0};
      8'h08:   e = '{OP_LDA_L,  1'b0, 1'b1, 1'b1};
      8'h09:   e = '{OP_STA_L,  1'b1, 1'b0, 1'b1};
      8'h0A:   e = '{OP_LD_L,   1'b1, 1'b1, 1'b0};
      8'h0B:   e = '{OP_ST_L,   1'b1, 1'b0, 1'b0};
      8'h0C:   e = '{OP_LDO_L,  1'b1, 1'b1, 1'b1};
      8'h0D:   e = '{OP_STO_L,  1'b1, 1'b0, 1'b1};
      8'h0E:   e = '{OP_CMP,    1'b1, 1'b0, 1'b0};
      8'h0F:   e = '{OP_NOP,    1'b0, 1'b0, 1'b0};
      8'h10:   e = '{OP_SEX_B,  1'b1, 1'b1, 1'b0};
      8'h11:   e = '{OP_SEX_S,  1'b1, 1'b1, 1'b0};
      8'h12:   e = '{OP_ZEX_B,  1'b1, 1'b1, 1'b0};
      8'h13:   e = '{OP_ZEX_S,  1'b1, 1'b1, 1'b0};
      8'h14:   e = '{OP_UMUL_X, 1'b1, 1'b1, 1'b0};
      8'h15:   e = '{OP_MUL_X,  1'b1, 1'b1, 1'b0};
      8'h19:   e = '{OP_JSR,    1'b1, 1'b0, 1'b0};
      8'h1A:   e = '{OP_JMPA,   1'b0, 1'b0, 1'b1};
      8'h25:   e = '{OP_JMP,    1'b1, 1'b0, 1'b0};
      8'h26:   e = '{OP_AND,    1'b1, 1'b1, 1'b0};
      8'h27:   e = '{OP_LSHR,   1'b1, 1'b1, 1'b0};
      8'h28:   e = '{OP_ASHL,   1'b1, 1'b1, 1'b0};
      8'h29:   e = '{OP_SUB_L,  1'b1, 1'b1, 1'b0};
      8'h2A:   e = '{OP_NEG,    1'b1, 1'b1, 1'b0};
      8'h2B:   e = '{OP_OR,     1'b1, 1'b1, 1'b0};
      8'h2C:   e = '{OP_NOT,    1'b1, 1'b1, 1'b0};
      8'h2D:   e = '{OP_ASHR,   1'b1, 1'b1, 1'b0};
      8'h2E:   e = '{OP_XOR,    1'b1, 1'b1, 1'b0};
      8'h2F:   e = '{OP_MUL_L,  1'b1, 1'b1, 1'b0};
      8'h30:   e = '{OP_SWI,    1'b0, 1'b0, 1'b1};
      8'h31:   e = '{OP_DIV_L,  1'b1, 1'b1, 1'b0};
      8'h32:   e = '{OP_UDIV_L, 1'b1, 1'b1, 1'b0};
      8'h33:   e = '{OP_MOD_L,  1'b1, 1'b1, 1'b0};
      8'h34:   e = '{OP_UMOD_L, 1'b1, 1'b1, 1'b0};
      8'h35:   e = '{OP_BRK,    1'b0, 1'b0, 1'b0};
      default: e = '{OP_BAD,    1'b0, 1'b0, 1'b0};
    endcase
    return e;
  endfunction

  function automatic dec_t decode_insn(input logic [15:0] insn);
    dec_t      d;
    f1_entry_t e;
    d.op    = OP_BAD;
    d.reg_a = insn[7:4];
    d.reg_b = insn[3:0];
    d.dest  = insn[7:4];
    d.rd    = 1'b0;
    d.wr    = 1'b0;
    d.opnd  = OPND_NONE;
    e       = f1_lookup(insn[15:8]);
    if ((insn & FORM_MASK) == FORM3_BITS) begin
      d.reg_a = 4'd0;
      d.reg_b = 4'd0;
      d.dest  = 4'd0;
      if (insn[13:10] <= BRANCH_LAST) begin
        d.op   = OP_BEQ + op_t'(insn[13:10]);
        d.opnd = OPND_SX10;
      end else begin
        d.op = OP_BAD;
      end
    end else if ((insn & FORM_MASK) == FORM2_BITS) begin
      // regB mirrors regA so the scoreboard never sees a phantom second source
      d.reg_a = insn[11:8];
      d.reg_b = insn[11:8];
      d.dest  = insn[11:8];
      d.opnd  = OPND_ZX8;
      case (insn[13:12])
        2'b00: begin d.op = OP_INC; d.rd = 1'b1; d.wr = 1'b1; end
        2'b01: begin d.op = OP_DEC; d.rd = 1'b1; d.wr = 1'b1; end
        2'b10: begin d.op = OP_GSR; d.wr = 1'b1; end
        2'b11: begin d.op = OP_SSR; d.rd = 1'b1; end
        default: d.op = OP_BAD;
      endcase
    end else begin
      d.op   = e.op;
      d.rd   = e.rd;
      d.wr   = e.wr;
      d.opnd = e.lng ? OPND_LONG : OPND_NONE;
    end
    return d;
  endfunction

endpackage

// File: rtl/cpu_scoreboard.sv
// Register scoreboard: one pending bit per register with an in-flight write,
// and the RAW/WAW hazard lookup for the instruction offered by fetch.
module cpu_scoreboard
  import cpu_pkg::*;
#(
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       set_i,
  input  logic [3:0] set_idx_i,
  input  logic       wb_valid_i,
  input  logic [3:0] wb_index_i,
  input  logic       kill_i,
  input  logic [3:0] kill_idx_i,
  input  logic       chk_valid_i,
  input  logic       chk_rd_i,
  input  logic       chk_wr_i,
  input  logic [3:0] chk_a_i,
  input  logic [3:0] chk_b_i,
  input  logic [3:0] chk_dest_i,
  output logic       hazard_o
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] next_s;
  logic [NUM_REGS-1:0] wb_clr_s;
  logic [NUM_REGS-1:0] kill_clr_s;
  logic [NUM_REGS-1:0] pend_s;

  // Clears apply first so a set to the same index in the same cycle wins.
  always_comb begin
    wb_clr_s               = {NUM_REGS{1'b0}};
    wb_clr_s[wb_index_i]   = wb_valid_i;
    kill_clr_s             = {NUM_REGS{1'b0}};
    kill_clr_s[kill_idx_i] = kill_i;
    next_s                 = pending_q & ~wb_clr_s & ~kill_clr_s;
    next_s[set_idx_i]      = next_s[set_idx_i] | set_i;
    pending_d              = HAZARD_EN ? next_s : {NUM_REGS{1'b0}};
    pend_s                 = pending_q & ~wb_clr_s;
    hazard_o               = HAZARD_EN && chk_valid_i &&
                             ((chk_rd_i && (pend_s[chk_a_i] || pend_s[chk_b_i])) ||
                              (chk_wr_i && pend_s[chk_dest_i]));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= {NUM_REGS{1'b0}};
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/cpu_decode_pipe.sv
// Moxie decode stage: decodes fetched opcodes into a one-entry registered
// output slot with valid/ready flow control and a register hazard scoreboard.
module cpu_decode_pipe
  import cpu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int OP_W      = 6,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [15:0]       opcode_i,
  input  logic [DATA_W-1:0] operand_i,
  output logic              ready_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [OP_W-1:0]   op_o,
  output logic [3:0]        regA_o,
  output logic [3:0]        regB_o,
  output logic [DATA_W-1:0] operand_o,
  output logic              register_read_enable_o,
  output logic              register_write_enable_o,
  output logic [3:0]        register_write_index_o,
  input  logic              wb_valid_i,
  input  logic [3:0]        wb_index_i,
  input  logic              flush_i
);

  dec_t              dec_s;
  logic [DATA_W-1:0] operand_s;
  logic              hazard_s;
  logic              accept_s;
  logic              kill_s;

  logic              valid_q,   valid_d;
  logic [OP_W-1:0]   op_q,      op_d;
  logic [3:0]        reg_a_q,   reg_a_d;
  logic [3:0]        reg_b_q,   reg_b_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic              rd_en_q,   rd_en_d;
  logic              wr_en_q,   wr_en_d;
  logic [3:0]        wr_idx_q,  wr_idx_d;

  always_comb begin
    dec_s = decode_insn(opcode_i);
    case (dec_s.opnd)
      OPND_LONG: operand_s = operand_i;
      OPND_ZX8:  operand_s = {{(DATA_W-8){1'b0}}, opcode_i[7:0]};
      OPND_SX10: operand_s = {{(DATA_W-10){opcode_i[9]}}, opcode_i[9:0]};
      default:   operand_s = {DATA_W{1'b0}};
    endcase
  end

  assign ready_o  = (!valid_q || ready_i) && !hazard_s && !flush_i;
  assign accept_s = valid_i && ready_o;
  // A killed slot never reaches writeback, so its pending bit is dropped here.
  assign kill_s   = flush_i && valid_q && wr_en_q;

  cpu_scoreboard #(
    .HAZARD_EN (HAZARD_EN)
  ) u_sb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .set_i       (accept_s && dec_s.wr),
    .set_idx_i   (dec_s.dest),
    .wb_valid_i  (wb_valid_i),
    .wb_index_i  (wb_index_i),
    .kill_i      (kill_s),
    .kill_idx_i  (wr_idx_q),
    .chk_valid_i (valid_i),
    .chk_rd_i    (dec_s.rd),
    .chk_wr_i    (dec_s.wr),
    .chk_a_i     (dec_s.reg_a),
    .chk_b_i     (dec_s.reg_b),
    .chk_dest_i  (dec_s.dest),
    .hazard_o    (hazard_s)
  );

  // Load on accept, empty on consume or flush (enables forced low), else hold.
  always_comb begin
    valid_d   = valid_q;
    op_d      = op_q;
    reg_a_d   = reg_a_q;
    reg_b_d   = reg_b_q;
    operand_d = operand_q;
    rd_en_d   = rd_en_q;
    wr_en_d   = wr_en_q;
    wr_idx_d  = wr_idx_q;
    if (accept_s) begin
      valid_d   = 1'b1;
      op_d      = OP_W'(dec_s.op);
      reg_a_d   = dec_s.reg_a;
      reg_b_d   = dec_s.reg_b;
      operand_d = operand_s;
      rd_en_d   = dec_s.rd;
      wr_en_d   = dec_s.wr;
      wr_idx_d  = dec_s.dest;
    end else if (flush_i || ready_i) begin
      valid_d = 1'b0;
      rd_en_d = 1'b0;
      wr_en_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      op_q      <= OP_W'(OP_NOP);
      reg_a_q   <= 4'd0;
      reg_b_q   <= 4'd0;
      operand_q <= {DATA_W{1'b0}};
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= 4'd0;
    end else begin
      valid_q   <= valid_d;
      op_q      <= op_d;
      reg_a_q   <= reg_a_d;
      reg_b_q   <= reg_b_d;
      operand_q <= operand_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
    end
  end

  assign valid_o                 = valid_q;
  assign op_o                    = op_q;
  assign regA_o                  = reg_a_q;
  assign regB_o                  = reg_b_q;
  assign operand_o               = operand_q;
  assign register_read_enable_o  = rd_en_q;
  assign register_write_enable_o = wr_en_q;
  assign register_write_index_o  = wr_idx_q;

endmodule

// File: tb/tb_cpu_decode_pipe.sv
// Bench for cpu_decode_pipe: a table of single-instruction decode vectors plus
// directed sequences for hazards, stalls, flush, set-wins and mid-stall reset.
module tb_cpu_decode_pipe;
  import cpu_pkg::*;

  localparam int DATA_W = 32;
  localparam int OP_W   = 6;
  localparam int NVEC   = 14;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              valid_i;
  logic [15:0]       opcode_i;
  logic [DATA_W-1:0] operand_i;
  logic              ready_o;
  logic              valid_o;
  logic              ready_i;
  logic [OP_W-1:0]   op_o;
  logic [3:0]        regA_o;
  logic [3:0]        regB_o;
  logic [DATA_W-1:0] operand_o;
  logic              register_read_enable_o;
  logic              register_write_enable_o;
  logic [3:0]        register_write_index_o;
  logic              wb_valid_i;
  logic [3:0]        wb_index_i;
  logic              flush_i;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] opc;
    logic [31:0] opnd_in;
    logic [5:0]  op;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  wi;
    logic [31:0] opnd;
    logic        rd;
    logic        wr;
  } vec_t;

  cpu_decode_pipe #(
    .DATA_W    (DATA_W),
    .OP_W      (OP_W),
    .HAZARD_EN (1'b1)
  ) u_dut (
    .clk_i                   (clk_i),
    .rst_i                   (rst_i),
    .valid_i                 (valid_i),
    .opcode_i                (opcode_i),
    .operand_i               (operand_i),
    .ready_o                 (ready_o),
    .valid_o                 (valid_o),
    .ready_i                 (ready_i),
    .op_o                    (op_o),
    .regA_o                  (regA_o),
    .regB_o                  (regB_o),
    .operand_o               (operand_o),
    .register_read_enable_o  (register_read_enable_o),
    .register_write_enable_o (register_write_enable_o),
    .register_write_index_o  (register_write_index_o),
    .wb_valid_i              (wb_valid_i),
    .wb_index_i              (wb_index_i),
    .flush_i                 (flush_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_slot(input string tag, input logic v, input logic [5:0] op,
                          input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] wi,
                          input logic [31:0] opnd, input logic rd, input logic wr);
    chk({tag, "_valid"}, valid_o, v);
    chk({tag, "_op"}, op_o, op);
    chk({tag, "_regA"}, regA_o, ra);
    chk({tag, "_regB"}, regB_o, rb);
    chk({tag, "_widx"}, register_write_index_o, wi);
    chk({tag, "_operand"}, operand_o, opnd);
    chk({tag, "_rd_en"}, register_read_enable_o, rd);
    chk({tag, "_wr_en"}, register_write_enable_o, wr);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [NVEC];
    rst_i = 1'b1; valid_i = 1'b0; opcode_i = 16'h0000; operand_i = 32'h0;
    ready_i = 1'b0; wb_valid_i = 1'b0; wb_index_i = 4'd0; flush_i = 1'b0;

    vecs[0]  = '{16'h0512, 32'hAAAA5555, OP_ADD_L,  4'd1, 4'd2,  4'd1, 32'h0,        1'b1, 1'b1};
    vecs[1]  = '{16'h0140, 32'hDEADBEEF, OP_LDI_L,  4'd4, 4'd0,  4'd4, 32'hDEADBEEF, 1'b0, 1'b1};
    vecs[2]  = '{16'h8305, 32'hAAAA5555, OP_INC,    4'd3, 4'd3,  4'd3, 32'h5,        1'b1, 1'b1};
    vecs[3]  = '{16'h93F0, 32'hAAAA5555, OP_DEC,    4'd3, 4'd3,  4'd3, 32'hF0,       1'b1, 1'b1};
    vecs[4]  = '{16'hC3FF, 32'hAAAA5555, OP_BEQ,    4'd0, 4'd0,  4'd0, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[5]  = '{16'hC5FE, 32'hAAAA5555, OP_BNE,    4'd0, 4'd0,  4'd0, 32'h1FE,      1'b0, 1'b0};
    vecs[6]  = '{16'hE800, 32'hAAAA5555, OP_BAD,    4'd0, 4'd0,  4'd0, 32'h0,        1'b0, 1'b0};
    vecs[7]  = '{16'h0000, 32'hAAAA5555, OP_NOP,    4'd0, 4'd0,  4'd0, 32'h0,        1'b0, 1'b0};
    vecs[8]  = '{16'h1756, 32'hAAAA5555, OP_BAD,    4'd5, 4'd6,  4'd5, 32'h0,        1'b0, 1'b0};
    vecs[9]  = '{16'h0E34, 32'hAAAA5555, OP_CMP,    4'd3, 4'd4,  4'd3, 32'h0,        1'b1, 1'b0};
    vecs[10] = '{16'h2978, 32'hAAAA5555, OP_SUB_L,  4'd7, 4'd8,  4'd7, 32'h0,        1'b1, 1'b1};
    vecs[11] = '{16'h0D9A, 32'h12345678, OP_STO_L,  4'd9, 4'd10, 4'd9, 32'h12345678, 1'b1, 1'b0};
    vecs[12] = '{16'hA2C7, 32'hAAAA5555, OP_GSR,    4'd2, 4'd2,  4'd2, 32'hC7,       1'b0, 1'b1};
    vecs[13] = '{16'h3456, 32'hAAAA5555, OP_UMOD_L, 4'd5, 4'd6,  4'd5, 32'h0,        1'b1, 1'b1};

    tick();
    tick();
    rst_i = 1'b0;
    #1;
    chk_slot("reset", 1'b0, OP_NOP, 4'd0, 4'd0, 4'd0, 32'h0, 1'b0, 1'b0);
    chk("reset_ready", ready_o, 1'b1);
    chk("reset_pending", u_dut.u_sb.pending_q, 16'h0000);

    // Table: accept, check slot, then drain with a writeback of the destination.
    for (int i = 0; i < NVEC; i++) begin
      valid_i = 1'b1; opcode_i = vecs[i].opc; operand_i = vecs[i].opnd_in; ready_i = 1'b1;
      #1 chk($sformatf("v%0d_ready", i), ready_o, 1'b1);
      tick();
      valid_i = 1'b0;
      chk_slot($sformatf("v%0d", i), 1'b1, vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].wi,
               vecs[i].opnd, vecs[i].rd, vecs[i].wr);
      wb_valid_i = vecs[i].wr; wb_index_i = vecs[i].wi;
      tick();
      wb_valid_i = 1'b0;
      chk($sformatf("v%0d_drain_valid", i), valid_o, 1'b0);
      chk($sformatf("v%0d_drain_wr", i), register_write_enable_o, 1'b0);
      chk($sformatf("v%0d_drain_pend", i), u_dut.u_sb.pending_q, 16'h0000);
    end

    // RAW hazard on r1, released by a same-cycle writeback.
    valid_i = 1'b1; opcode_i = 16'h0512; operand_i = 32'h0; ready_i = 1'b1;
    tick();
    chk_slot("add", 1'b1, OP_ADD_L, 4'd1, 4'd2, 4'd1, 32'h0, 1'b1, 1'b1);
    chk("add_pend1", u_dut.u_sb.pending_q[1], 1'b1);
    opcode_i = 16'h0231;
    #1 chk("raw_ready", ready_o, 1'b0);
    tick();
    chk("raw_stall_valid", valid_o, 1'b0);
    wb_valid_i = 1'b1; wb_index_i = 4'd1;
    #1 chk("raw_wb_ready", ready_o, 1'b1);
    tick();
    wb_valid_i = 1'b0; valid_i = 1'b0;
    chk_slot("mov", 1'b1, OP_MOV, 4'd3, 4'd1, 4'd3, 32'h0, 1'b1, 1'b1);
    chk("mov_pend1", u_dut.u_sb.pending_q[1], 1'b0);
    chk("mov_pend3", u_dut.u_sb.pending_q[3], 1'b1);
    wb_valid_i = 1'b1; wb_index_i = 4'd3;
    tick();
    wb_valid_i = 1'b0;

    // ldi.l held for three back-pressured cycles, then consumed.
    valid_i = 1'b1; opcode_i = 16'h0140; operand_i = 32'hDEADBEEF; ready_i = 1'b0;
    tick();
    opcode_i = 16'h0E00; operand_i = 32'h0;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("stall%0d_ready", c), ready_o, 1'b0);
      chk_slot($sformatf("stall%0d", c), 1'b1, OP_LDI_L, 4'd4, 4'd0, 4'd4, 32'hDEADBEEF, 1'b0, 1'b1);
      tick();
    end
    chk_slot("stall_end", 1'b1, OP_LDI_L, 4'd4, 4'd0, 4'd4, 32'hDEADBEEF, 1'b0, 1'b1);
    valid_i = 1'b0; ready_i = 1'b1; wb_valid_i = 1'b1; wb_index_i = 4'd4;
    tick();
    wb_valid_i = 1'b0;
    chk("consume_valid", valid_o, 1'b0);
    chk("consume_wr", register_write_enable_o, 1'b0);

    // Flush a slot writing r4 while another instruction is offered.
    valid_i = 1'b1; opcode_i = 16'h0245; ready_i = 1'b0;
    tick();
    chk("fl_valid", valid_o, 1'b1);
    chk("fl_pend4", u_dut.u_sb.pending_q[4], 1'b1);
    opcode_i = 16'h0567; flush_i = 1'b1;
    #1 chk("fl_ready", ready_o, 1'b0);
    tick();
    flush_i = 1'b0; valid_i = 1'b0;
    chk("fl_killed", valid_o, 1'b0);
    chk("fl_pend4_clr", u_dut.u_sb.pending_q[4], 1'b0);
    chk("fl_no_accept", u_dut.u_sb.pending_q[6], 1'b0);

    // Writeback of r6 in the same cycle as a new writer of r6: set wins.
    valid_i = 1'b1; opcode_i = 16'h0567; ready_i = 1'b1;
    tick();
    chk("sw_pend6_first", u_dut.u_sb.pending_q[6], 1'b1);
    opcode_i = 16'h0260; wb_valid_i = 1'b1; wb_index_i = 4'd6;
    #1 chk("sw_ready", ready_o, 1'b1);
    tick();
    wb_valid_i = 1'b0;
    chk_slot("sw", 1'b1, OP_MOV, 4'd6, 4'd0, 4'd6, 32'h0, 1'b1, 1'b1);
    chk("sw_pend6", u_dut.u_sb.pending_q[6], 1'b1);

    // Reset while the slot is stalled.
    opcode_i = 16'h0512; ready_i = 1'b0;
    #1 chk("mid_ready", ready_o, 1'b0);
    tick();
    chk("mid_hold", valid_o, 1'b1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; valid_i = 1'b0;
    #1;
    chk_slot("mid_rst", 1'b0, OP_NOP, 4'd0, 4'd0, 4'd0, 32'h0, 1'b0, 1'b0);
    chk("mid_rst_pending", u_dut.u_sb.pending_q, 16'h0000);
    chk("mid_rst_ready", ready_o, 1'b1);
    valid_i = 1'b1; opcode_i = 16'h0567;
    #1 chk("mid_rst_r6_free", ready_o, 1'b1);

    // Back-to-back independent instructions at one per cycle.
    opcode_i = 16'h0512; ready_i = 1'b1;
    tick();
    chk("b2b_first_regA", regA_o, 4'd1);
    opcode_i = 16'h0534;
    #1 chk("b2b_ready", ready_o, 1'b1);
    tick();
    valid_i = 1'b0;
    chk("b2b_valid", valid_o, 1'b1);
    chk("b2b_regA", regA_o, 4'd3);
    chk("b2b_regB", regB_o, 4'd4);
    chk("b2b_pend", u_dut.u_sb.pending_q, 16'h000A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
